// File: rtl/datapath_pkg.sv
// Shared constants and types for the execute datapath.
// Register file geometry and ALU opcode encoding.
package datapath_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SLL = 3'b110,
    OP_BEQ = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Decode/writeback side bundle for the execute datapath.
// master drives control and write data, slave returns ALU outputs.
interface alu_regfile_datapath_if;
  import datapath_pkg::*;

  logic       reg_write;
  addr_t      rd0_addr;
  addr_t      rd1_addr;
  addr_t      wr_addr;
  word_t      wr_data;
  logic       alu_src1;
  logic       alu_src2;
  word_t      alu_imm;
  logic [2:0] alu_op;
  word_t      input1;
  word_t      input2;
  word_t      result;
  logic       take_branch;
  logic       ovf;

  modport master (
    output reg_write, rd0_addr, rd1_addr,
    output wr_addr, wr_data,
    output alu_src1, alu_src2,
    output alu_imm, alu_op,
    input  input1, input2, result,
    input  take_branch, ovf
  );

  modport slave (
    input  reg_write, rd0_addr, rd1_addr,
    input  wr_addr, wr_data,
    input  alu_src1, alu_src2,
    input  alu_imm, alu_op,
    output input1, input2, result,
    output take_branch, ovf
  );

endinterface

// File: rtl/reg_file.sv
// 8x16 register file: two async read ports,
// one sync write port, async active-low clear.
module reg_file
  import datapath_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  addr_t rd0_addr,
  output word_t rd0_data,
  input  addr_t rd1_addr,
  output word_t rd1_data
);

  word_t mem [NUM_REGS];

  // Clear all entries on reset; otherwise store on write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // No write bypass: new data is visible only after the edge.
  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

endmodule

// File: rtl/alu_regfile_datapath.sv
// Single-cycle execute datapath: register file,
// operand muxes and a 16-bit ALU with branch compare.
module alu_regfile_datapath
  import datapath_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  alu_regfile_datapath_if.slave  dp
);

  word_t   rd0_data;
  word_t   rd1_data;
  word_t   op_a;
  word_t   op_b;
  word_t   res;
  logic    br;
  logic    ov;
  alu_op_t op;

  reg_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (dp.reg_write),
    .wr_addr  (dp.wr_addr),
    .wr_data  (dp.wr_data),
    .rd0_addr (dp.rd0_addr),
    .rd0_data (rd0_data),
    .rd1_addr (dp.rd1_addr),
    .rd1_data (rd1_data)
  );

  // Zero for operand A comes from the mux, not a hardwired register.
  assign op_a = dp.alu_src1 ? '0 : rd0_data;
  assign op_b = dp.alu_src2 ? dp.alu_imm : rd1_data;
  assign op   = alu_op_t'(dp.alu_op);

  // ALU: overflow only for ADD/SUB, branch only for BEQ.
  always_comb begin
    res = '0;
    br  = 1'b0;
    ov  = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = op_a + op_b;
        ov  = (op_a[15] == op_b[15]) &&
              (res[15] != op_a[15]);
      end
      OP_SUB: begin
        res = op_a - op_b;
        ov  = (op_a[15] != op_b[15]) &&
              (res[15] != op_a[15]);
      end
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_NOT: res = ~op_a;
      OP_SLL: res = op_a << op_b[3:0];
      OP_BEQ: br  = (op_a == op_b);
    endcase
  end

  assign dp.input1      = op_a;
  assign dp.input2      = op_b;
  assign dp.result      = res;
  assign dp.take_branch = br;
  assign dp.ovf         = ov;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath with a
// behavioural reference model checked every negedge.
module tb_alu_regfile_datapath;

  logic clk;
  logic rst;
  logic cmp_en;
  int   n_chk;
  int   n_err;

  logic [15:0] mdl [8];

  alu_regfile_datapath_if dp_if ();

  alu_regfile_datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference register state.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) mdl[i] <= 16'h0;
    end else if (dp_if.reg_write) begin
      mdl[dp_if.wr_addr] <= dp_if.wr_data;
    end
  end

  // Reference ALU using integer arithmetic.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        t;
      logic        o;
      int          sa;
      int          sb;
      int          s;
      a  = dp_if.alu_src1 ? 16'h0 : mdl[dp_if.rd0_addr];
      b  = dp_if.alu_src2 ? dp_if.alu_imm
                          : mdl[dp_if.rd1_addr];
      sa = $signed(a);
      sb = $signed(b);
      r  = 16'h0;
      t  = 1'b0;
      o  = 1'b0;
      case (dp_if.alu_op)
        3'd0: begin
          s = sa + sb;
          r = s[15:0];
          o = (s > 32767) || (s < -32768);
        end
        3'd1: begin
          s = sa - sb;
          r = s[15:0];
          o = (s > 32767) || (s < -32768);
        end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = 16'hFFFF - a;
        3'd6: begin
          s = int'(a) * (2 ** int'(b[3:0]));
          r = s[15:0];
        end
        default: t = (a == b);
      endcase
      chk("m_input1", dp_if.input1, a);
      chk("m_input2", dp_if.input2, b);
      chk("m_result", dp_if.result, r);
      chk("m_branch", {15'h0, dp_if.take_branch}, {15'h0, t});
      chk("m_ovf", {15'h0, dp_if.ovf}, {15'h0, o});
    end
  end

  task automatic wr(input logic [2:0] ad,
                    input logic [15:0] d);
    @(posedge clk); #1;
    dp_if.reg_write = 1'b1;
    dp_if.wr_addr   = ad;
    dp_if.wr_data   = d;
    @(posedge clk); #1;
    dp_if.reg_write = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    dp_if.reg_write = 1'b0;
    dp_if.rd0_addr  = 3'd0;
    dp_if.rd1_addr  = 3'd0;
    dp_if.wr_addr   = 3'd0;
    dp_if.wr_data   = 16'h0;
    dp_if.alu_src1  = 1'b0;
    dp_if.alu_src2  = 1'b0;
    dp_if.alu_imm   = 16'h0;
    dp_if.alu_op    = 3'd0;
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // writes during reset are ignored
    dp_if.reg_write = 1'b1;
    dp_if.wr_addr   = 3'd2;
    dp_if.wr_data   = 16'h5555;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    dp_if.reg_write = 1'b0;

    dp_if.alu_src1 = 1'b1;
    dp_if.alu_src2 = 1'b0;
    dp_if.alu_op   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      dp_if.rd1_addr = 3'(i);
      settle();
      chk("rst_sweep", dp_if.result, 16'h0);
    end

    dp_if.alu_src2 = 1'b1;
    dp_if.alu_imm  = 16'h000C;
    settle();
    chk("imm_in1", dp_if.input1, 16'h0);
    chk("imm_in2", dp_if.input2, 16'h000C);
    chk("imm_res", dp_if.result, 16'h000C);
    chk("imm_ovf", {15'h0, dp_if.ovf}, 16'h0);
    chk("imm_br", {15'h0, dp_if.take_branch}, 16'h0);

    @(posedge clk); #1;
    dp_if.reg_write = 1'b1;
    dp_if.wr_addr   = 3'd3;
    dp_if.wr_data   = 16'h1234;
    dp_if.rd0_addr  = 3'd3;
    dp_if.alu_src1  = 1'b0;
    dp_if.alu_imm   = 16'h0001;
    settle();
    chk("pre_edge", dp_if.input1, 16'h0);
    @(posedge clk); #1;
    chk("post_edge", dp_if.input1, 16'h1234);
    dp_if.reg_write = 1'b0;
    chk("r3_add", dp_if.result, 16'h1235);

    wr(3'd1, 16'h7FFF);
    dp_if.rd0_addr = 3'd1;
    settle();
    chk("add_ovf_res", dp_if.result, 16'h8000);
    chk("add_ovf", {15'h0, dp_if.ovf}, 16'h1);

    wr(3'd2, 16'h8000);
    dp_if.rd0_addr = 3'd2;
    dp_if.alu_op   = 3'd1;
    settle();
    chk("sub_ovf_res", dp_if.result, 16'h7FFF);
    chk("sub_ovf", {15'h0, dp_if.ovf}, 16'h1);

    dp_if.alu_op  = 3'd0;
    dp_if.alu_imm = 16'h8000;
    settle();
    chk("neg_ovf_res", dp_if.result, 16'h0000);
    chk("neg_ovf", {15'h0, dp_if.ovf}, 16'h1);

    wr(3'd4, 16'h00AA);
    wr(3'd5, 16'h00AA);
    dp_if.rd0_addr = 3'd4;
    dp_if.rd1_addr = 3'd5;
    dp_if.alu_src2 = 1'b0;
    dp_if.alu_op   = 3'd7;
    settle();
    chk("beq_take", {15'h0, dp_if.take_branch}, 16'h1);
    chk("beq_res", dp_if.result, 16'h0);
    wr(3'd5, 16'h00AB);
    settle();
    chk("beq_drop", {15'h0, dp_if.take_branch}, 16'h0);

    for (int op = 0; op < 8; op++) begin
      dp_if.alu_op = 3'(op);
      settle();
    end
    dp_if.alu_src2 = 1'b1;
    dp_if.alu_imm  = 16'h0013;
    for (int op = 0; op < 8; op++) begin
      dp_if.alu_op = 3'(op);
      settle();
    end
    dp_if.alu_op = 3'd6;
    settle();
    chk("sll_lit", dp_if.result, 16'h0550);
    dp_if.alu_op = 3'd5;
    settle();
    chk("not_lit", dp_if.result, 16'hFF55);

    wr(3'd6, 16'hBEEF);
    dp_if.rd0_addr = 3'd6;
    dp_if.alu_op   = 3'd0;
    dp_if.alu_imm  = 16'h0;
    settle();
    chk("r6_set", dp_if.input1, 16'hBEEF);
    #2 rst = 1'b0;
    #1;
    chk("async_clr", dp_if.input1, 16'h0);
    dp_if.reg_write = 1'b1;
    dp_if.wr_addr   = 3'd6;
    dp_if.wr_data   = 16'h1111;
    @(posedge clk); #1;
    chk("rst_nowr", dp_if.input1, 16'h0);
    dp_if.reg_write = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    settle();
    chk("rst_rel", dp_if.input1, 16'h0);
    wr(3'd6, 16'h2222);
    settle();
    chk("post_rst_wr", dp_if.input1, 16'h2222);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_regfile_datapath.md
# alu_regfile_datapath

Single-cycle execute datapath for the 16-bit teaching CPU: an 8×16 register file feeds two operand-select muxes and a 16-bit ALU. It sits between the decode stage (which supplies register addresses, immediate, and control) and writeback (which returns `wr_data`). The register file is the only stateful element; everything from read address to ALU outputs is combinational.

## Interface
- No parameters. Data width is 16 and address width is 3, fixed via package constants.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `reg_write` in 1: register-file write enable.
- `rd0_addr` in 3: read port 0 address (operand A source).
- `rd1_addr` in 3: read port 1 address (operand B source).
- `wr_addr` in 3: write address.
- `wr_data` in 16: write data.
- `alu_src1` in 1: 1 selects 16'h0000 for operand A; 0 selects read port 0 data.
- `alu_src2` in 1: 1 selects `alu_imm` for operand B; 0 selects read port 1 data.
- `alu_imm` in 16: immediate operand from the instruction.
- `alu_op` in 3: ALU operation select.
- `input1` out 16: selected operand A.
- `input2` out 16: selected operand B.
- `result` out 16: ALU result.
- `take_branch` out 1: branch condition.
- `ovf` out 1: signed overflow.

## Operation
- Register file: 8 entries of 16 bits each. Two asynchronous read ports. One synchronous write port.
- All 8 entries are writable. There is no hardwired zero register; the zero comes from the mux.
- ALU opcodes (a = `input1`, b = `input2`):
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~a.
  - 110 SLL: a << b[3:0].
  - 111 BEQ: result = 16'h0000, `take_branch` = (a == b).
- `take_branch` is 0 for every op other than 111.
- `ovf` applies to ADD and SUB only. It is the signed two's-complement overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
- `ovf` is 0 for all other ops.
- Results wrap modulo 2^16. There is no carry output.

## Timing
- `rst` low asynchronously clears all 8 registers to 16'h0000, independent of `clk`.
  - While `rst` is low, writes are ignored.
  - Outputs remain combinational functions of the cleared registers and the current control inputs.
- Write takes effect on a rising `clk` edge when `rst` is high and `reg_write` = 1: `wr_data` is stored at `wr_addr`.
- Read is zero-latency and combinational.
  - Reading `wr_addr` during a write cycle returns the old value until the edge.
  - The new value appears in the same delta after the edge (no bypass).
- Reset released mid-cycle: the first write occurs on the next rising edge with `rst` high.
- All outputs settle combinationally within the cycle; there are no output registers.

## Structure
- Shared package `datapath_pkg` contains:
  - `DATA_W` = 16, `ADDR_W` = 3, `NUM_REGS` = 8.
  - A typedef enum `alu_op_t` with the eight opcodes above.
- One sub-module is natural: `reg_file` (clk, rst, wr_en, two read ports, one write port).
- The operand muxes and the ALU are combinational logic in the top module.

## Test plan
- Reset: hold `rst` low, then release. Set `alu_src1`=1, `alu_src2`=0, `alu_op`=ADD, and sweep `rd1_addr` 0–7. Every `result` must be 16'h0000.
- Immediate path: `alu_src1`=1, `alu_src2`=1, `alu_imm`=16'h000C, `alu_op`=000. Expect `input1`=0, `input2`=16'h000C, `result`=16'h000C, `ovf`=0, `take_branch`=0.
- Write/read:
  - Write R3=16'h1234. Before the edge, `rd0_addr`=3 shows 16'h0000; after the edge it shows 16'h1234.
  - Then `alu_src1`=0, imm 16'h0001, ADD gives 16'h1235.
- Overflow:
  - R1=16'h7FFF, imm 16'h0001, ADD gives 16'h8000 with `ovf`=1.
  - R2=16'h8000, imm 16'h0001, SUB gives 16'h7FFF with `ovf`=1.
- Branch:
  - R4=R5=16'h00AA, `alu_src2`=0, op 111 gives `take_branch`=1 and `result`=0.
  - Change R5 to 16'h00AB and `take_branch` must drop to 0.
- Async reset mid-run: after writing R6=16'hBEEF, pull `rst` low between clock edges. Read of R6 must immediately return 16'h0000.
